// File: rtl/vga_timing.sv
`default_nettype none
//============================================================================
// Module   : vga_timing
// Purpose  : VGA horizontal/vertical counters with sync, blanking and
//            line/frame pulses. Define VGA_TIMING_CLKDIV_EN to insert a
//            divide-by-two pixel tick (e.g. 50 MHz clk -> 25 MHz pixels).
// Revision : 1.0 - initial release
//============================================================================
module vga_timing #(
    parameter int N         = 11,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_en,
    output logic [N-1:0] Contador_H,
    output logic [N-1:0] Contador_V,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         line_end,
    output logic         frame_start
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [N-1:0] c_h_last = N'(c_h_total - 1);
    localparam logic [N-1:0] c_v_last = N'(c_v_total - 1);

    // A count that cannot reach TOTAL-1 in N bits would silently alias.
    if ((c_h_total - 1) >= (2 ** N)) begin : g_h_width_err
        $error("vga_timing: H_TOTAL-1 does not fit in N bits");
    end
    if ((c_v_total - 1) >= (2 ** N)) begin : g_v_width_err
        $error("vga_timing: V_TOTAL-1 does not fit in N bits");
    end

    logic [N-1:0] r_cnt_h;
    logic [N-1:0] r_cnt_v;
    logic         r_line_end;
    logic         r_frame_start;
    logic         w_tick;

`ifdef VGA_TIMING_CLKDIV_EN
    logic r_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= 1'b0;
        end else if (pix_en) begin
            r_div <= ~r_div;
        end
    end

    assign w_tick = pix_en & r_div;
`else
    assign w_tick = pix_en;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_h       <= '0;
            r_cnt_v       <= '0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                if (r_cnt_h == c_h_last) begin
                    r_cnt_h    <= '0;
                    r_line_end <= 1'b1;
                    if (r_cnt_v == c_v_last) begin
                        r_cnt_v       <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_cnt_v <= r_cnt_v + 1'b1;
                    end
                end else begin
                    r_cnt_h <= r_cnt_h + 1'b1;
                end
            end
        end
    end

    // Decodes compare in 32 bits so a sync window ending exactly at 2**N is safe.
    always_comb begin
        hsync    = !((int'(r_cnt_h) >= H_VISIBLE + H_FRONT) &&
                     (int'(r_cnt_h) <  H_VISIBLE + H_FRONT + H_SYNC));
        vsync    = !((int'(r_cnt_v) >= V_VISIBLE + V_FRONT) &&
                     (int'(r_cnt_v) <  V_VISIBLE + V_FRONT + V_SYNC));
        video_on = (int'(r_cnt_h) < H_VISIBLE) && (int'(r_cnt_v) < V_VISIBLE);
    end

    assign Contador_H  = r_cnt_h;
    assign Contador_V  = r_cnt_v;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
//============================================================================
// Module   : tb_vga_timing
// Purpose  : Directed self-checking bench for vga_timing. Vertical timing is
//            shortened (24/4/2/6 lines, 36 total) so a full frame is 28800 ticks.
// Revision : 1.0 - initial release
//============================================================================
module tb_vga_timing;

    localparam int N = 11;

    logic         clk;
    logic         rst_n;
    logic         pix_en;
    logic [N-1:0] Contador_H;
    logic [N-1:0] Contador_V;
    logic         hsync;
    logic         vsync;
    logic         video_on;
    logic         line_end;
    logic         frame_start;

    int n_checks;
    int n_fails;
    int tick_count;

    vga_timing #(
        .N         (N),
        .H_VISIBLE (640),
        .H_FRONT   (16),
        .H_SYNC    (96),
        .H_BACK    (48),
        .V_VISIBLE (24),
        .V_FRONT   (4),
        .V_SYNC    (2),
        .V_BACK    (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .Contador_H  (Contador_H),
        .Contador_V  (Contador_V),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive pix_en for one edge, then sample 1 time unit after it.
    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en && rst_n) tick_count++;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " H"}, 32'(Contador_H), 0);
        check_eq({tag, " V"}, 32'(Contador_V), 0);
        check_eq({tag, " hsync"}, 32'(hsync), 1);
        check_eq({tag, " vsync"}, 32'(vsync), 1);
        check_eq({tag, " video_on"}, 32'(video_on), 1);
        check_eq({tag, " line_end"}, 32'(line_end), 0);
        check_eq({tag, " frame_start"}, 32'(frame_start), 0);
    endtask

`ifndef VGA_TIMING_CLKDIV_EN
    int le_cnt, hs_low, hs_first, hs_last, vid_off_first;
    int fs_cnt, vs_low, vs_first, vs_last, remaining;
    int exp_h, exp_v, exp_le;
    logic en;

    initial begin
        n_checks = 0; n_fails = 0; tick_count = 0;
        rst_n = 1'b0; pix_en = 1'b1;
        repeat (3) step(1'b1);
        check_reset_state("reset");

        // One full line at pix_en=1
        rst_n = 1'b1;
        le_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1; vid_off_first = -1;
        for (int k = 0; k < 800; k++) begin
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(Contador_H);
                hs_last = int'(Contador_H);
            end
            if (!video_on && vid_off_first < 0) vid_off_first = int'(Contador_H);
            if (k == 799) begin
                check_eq("line H before wrap", 32'(Contador_H), 799);
                check_eq("line V before wrap", 32'(Contador_V), 0);
            end
            step(1'b1);
            if (line_end) le_cnt++;
        end
        check_eq("line wrap H", 32'(Contador_H), 0);
        check_eq("line wrap V", 32'(Contador_V), 1);
        check_eq("line_end at wrap", 32'(line_end), 1);
        check_eq("line_end count", 32'(le_cnt), 1);
        check_eq("hsync low ticks", 32'(hs_low), 96);
        check_eq("hsync first H", 32'(hs_first), 656);
        check_eq("hsync last H", 32'(hs_last), 751);
        check_eq("video_on first off H", 32'(vid_off_first), 640);

        // Random pix_en: counters move only on enabled clks
        exp_h = 0; exp_v = 1;
        for (int i = 0; i < 2000; i++) begin
            en = 1'($urandom_range(0, 1));
            step(en);
            exp_le = 0;
            if (en) begin
                if (exp_h == 799) begin
                    exp_h = 0; exp_v++; exp_le = 1;
                end else begin
                    exp_h++;
                end
            end
            check_eq("rand H", 32'(Contador_H), 32'(exp_h));
            check_eq("rand V", 32'(Contador_V), 32'(exp_v));
            check_eq("rand line_end", 32'(line_end), 32'(exp_le));
            check_eq("rand frame_start", 32'(frame_start), 0);
        end

        // Through the frame wrap, stopping at H=300, V=20 of the next frame
        fs_cnt = 0; vs_low = 0; vs_first = -1; vs_last = -1;
        remaining = 28800 - tick_count + 20 * 800 + 300;
        for (int i = 0; i < remaining; i++) begin
            step(1'b1);
            if (frame_start) begin
                fs_cnt++;
                check_eq("frame_start H", 32'(Contador_H), 0);
                check_eq("frame_start V", 32'(Contador_V), 0);
            end
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(Contador_V);
                vs_last = int'(Contador_V);
            end
            if (fs_cnt == 0 && Contador_V == 11'd24 && Contador_H == 11'd0)
                check_eq("video_on blank line 24", 32'(video_on), 0);
            if (fs_cnt == 0 && Contador_V == 11'd23 && Contador_H == 11'd639)
                check_eq("video_on last visible", 32'(video_on), 1);
        end
        check_eq("frame_start count", 32'(fs_cnt), 1);
        check_eq("vsync low ticks", 32'(vs_low), 1600);
        check_eq("vsync first line", 32'(vs_first), 28);
        check_eq("vsync last line", 32'(vs_last), 29);
        check_eq("mid-frame H", 32'(Contador_H), 300);
        check_eq("mid-frame V", 32'(Contador_V), 20);

        // Reset mid-frame with pix_en=1 wins over the tick
        rst_n = 1'b0;
        step(1'b1);
        check_reset_state("mid reset");
        rst_n = 1'b1;
        step(1'b0);
        check_eq("release idle H", 32'(Contador_H), 0);
        check_eq("release frame_start", 32'(frame_start), 0);
        step(1'b1);
        check_eq("first tick H", 32'(Contador_H), 1);
        check_eq("first tick V", 32'(Contador_V), 0);
        check_eq("first tick frame_start", 32'(frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
`else
    int le_cnt;

    initial begin
        n_checks = 0; n_fails = 0; tick_count = 0;
        rst_n = 1'b0; pix_en = 1'b1;
        repeat (3) step(1'b1);
        check_reset_state("reset");

        // Divider starts at 0: ticks land on every second enabled clk
        rst_n = 1'b1;
        le_cnt = 0;
        step(1'b1);
        check_eq("div clk1 H", 32'(Contador_H), 0);
        step(1'b1);
        check_eq("div clk2 H", 32'(Contador_H), 1);
        for (int i = 2; i < 1599; i++) begin
            step(1'b1);
            if (line_end) le_cnt++;
        end
        check_eq("div H before wrap", 32'(Contador_H), 799);
        check_eq("div V before wrap", 32'(Contador_V), 0);
        step(1'b1);
        if (line_end) le_cnt++;
        check_eq("div line_end count", 32'(le_cnt), 1);
        check_eq("div wrap H", 32'(Contador_H), 0);
        check_eq("div wrap V", 32'(Contador_V), 1);
        step(1'b1);
        check_eq("div odd clk H", 32'(Contador_H), 0);
        check_eq("div pulse width", 32'(line_end), 0);
        step(1'b0);
        check_eq("div idle H", 32'(Contador_H), 0);
        step(1'b1);
        check_eq("div held phase H", 32'(Contador_H), 1);

        rst_n = 1'b0;
        step(1'b1);
        check_reset_state("mid reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
`endif

endmodule
`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter N, default 11, counter width in bits.
REQ-002 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-003 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-004 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-005 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-006 SHALL have parameters V_VISIBLE, V_FRONT, V_SYNC and V_BACK, defaults 480, 10, 2 and 33, in lines.
REQ-007 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port pix_en, input, 1 bit: pixel advance enable.
REQ-010 SHALL have port Contador_H, output, N bits: current horizontal count.
REQ-011 SHALL have port Contador_V, output, N bits: current vertical count.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-014 SHALL have port video_on, output, 1 bit: high inside the visible area.
REQ-015 SHALL have port line_end, output, 1 bit: one-clk pulse on horizontal wrap.
REQ-016 SHALL have port frame_start, output, 1 bit: one-clk pulse on full-frame wrap.

Function
REQ-017 SHALL define H_TOTAL as H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL as the vertical sum (default 525).
REQ-018 SHALL define tick as pix_en, gated as described in REQ-031.
REQ-019 SHALL hold both counters unchanged on a clk edge when tick is 0.
REQ-020 SHALL, on tick with Contador_H < H_TOTAL-1, increment Contador_H by 1 and hold Contador_V.
REQ-021 SHALL, on tick with Contador_H == H_TOTAL-1, load Contador_H with 0 and register line_end=1 for exactly that one clk.
REQ-022 SHALL, on the wrap in REQ-021: increment Contador_V if it is < V_TOTAL-1; otherwise load it with 0 and register frame_start=1 for one clk.
REQ-023 SHALL hold line_end and frame_start at 0 in every other clk, including clks where tick is 0.
REQ-024 SHALL drive hsync, vsync and video_on as combinational decodes of the registered counters, with zero added latency:
- hsync=0 iff H_VISIBLE+H_FRONT <= Contador_H < H_VISIBLE+H_FRONT+H_SYNC (default 656..751);
- vsync=0 iff V_VISIBLE+V_FRONT <= Contador_V < V_VISIBLE+V_FRONT+V_SYNC (default 490..491);
- video_on=1 iff Contador_H < H_VISIBLE and Contador_V < V_VISIBLE.
REQ-025 SHALL perform all counter arithmetic in N bits; no count shall ever exceed TOTAL-1.
REQ-026 SHALL flag an elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in N bits.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, set Contador_H=0, Contador_V=0, line_end=0 and frame_start=0, regardless of pix_en.
REQ-028 SHALL, during and immediately after reset, decode to hsync=1, vsync=1 and video_on=1.
REQ-029 SHALL let reset asserted mid-line or mid-frame take priority over any tick in the same clk.
REQ-030 SHALL start counting on the first tick after rst_n returns high; no frame_start pulse shall accompany reset release.

Configuration
REQ-031 SHALL, when VGA_TIMING_CLKDIV_EN is defined, add an internal 1-bit divider (reset to 0) that toggles on each clk with pix_en=1, and define tick = pix_en AND divider==1, halving the pixel rate (50 MHz clk yielding 25 MHz pixels).
REQ-032 SHALL, when VGA_TIMING_CLKDIV_EN is not defined, contain no divider, with tick = pix_en.

Verification
REQ-033 SHALL verify: pix_en held at 1, 800 ticks from reset -> Contador_H runs 0..799, line_end pulses once with Contador_H returning to 0, and Contador_V becomes 1.
REQ-034 SHALL verify: ticks through one line -> hsync low exactly for Contador_H 656..751 (96 ticks) and video_on low from Contador_H 640.
REQ-035 SHALL verify: 420000 ticks -> frame_start pulses exactly once, with both counters at 0; vsync low for lines 490..491 (1600 ticks).
REQ-036 SHALL verify: pix_en toggled randomly -> counters advance only on clks with pix_en=1; no pulse appears on idle clks.
REQ-037 SHALL verify: rst_n driven low at Contador_H=300, Contador_V=200 with pix_en=1 -> next edge gives 0/0, hsync=1, vsync=1 and frame_start=0.
REQ-038 SHALL verify, with VGA_TIMING_CLKDIV_EN defined: pix_en=1 for 1600 clks -> exactly one line completes (line_end once, Contador_V=1).
